// File: rtl/rv_mem_arb_pkg.sv
// Shared types for the BRAM port arbiter: requester encoding, fetch NOP
// constant and the in-flight read tag record.
package rv_mem_arb_pkg;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_D  = 1'b1
  } src_e;

  localparam logic [31:0] RV_NOP = 32'h00000013;

  typedef struct packed {
    logic valid;
    src_e src;
    logic oor;
  } tag_t;

  localparam tag_t TAG_IDLE = '{valid: 1'b0, src: SRC_IF, oor: 1'b0};

endpackage

// File: rtl/arb_tag_pipe.sv
// LAT-deep shift register of read tags; the tail stage lines up with the
// BRAM read data of the access that pushed it.
module arb_tag_pipe
  import rv_mem_arb_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t push,
  output tag_t tail,
  output logic busy
);

  tag_t stages [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        stages[i] <= TAG_IDLE;
      end
    end else begin
      stages[0] <= push;
      for (int unsigned i = 1; i < LAT; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign tail = stages[LAT-1];

  always_comb begin
    busy = 1'b0;
    for (int unsigned i = 0; i < LAT; i++) begin
      busy = busy | stages[i].valid;
    end
  end

endmodule

// File: rtl/rv_bram_port_arbiter.sv
// Arbitrates the fetch and data ports onto one fixed-latency BRAM, with
// starvation-limited data priority and tag-steered read responses.
module rv_bram_port_arbiter
  import rv_mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LAT        = 2,
  parameter int DEPTH      = 256,
  parameter int STARVE_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     if_req,
  input  logic [ADDR_W-1:0]        if_addr,
  output logic                     if_gnt,
  output logic                     if_rvalid,
  output logic [DATA_W-1:0]        if_rdata,
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [ADDR_W-1:0]        d_addr,
  input  logic [DATA_W-1:0]        d_wdata,
  output logic                     d_gnt,
  output logic                     d_rvalid,
  output logic [DATA_W-1:0]        d_rdata,
  output logic                     bram_en,
  output logic                     bram_we,
  output logic [$clog2(DEPTH)-1:0] bram_addr,
  output logic [DATA_W-1:0]        bram_wdata,
  input  logic [DATA_W-1:0]        bram_rdata,
  output logic                     busy
);

  localparam int AW    = $clog2(DEPTH);
  localparam int WW    = ADDR_W - 2;
  localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] DEPTH_LIM  = ADDR_W'(DEPTH);

  generate
    if (LAT < 1 || LAT > 4) begin : g_bad_lat
      $error("rv_bram_port_arbiter: LAT must be 1..4");
    end
  endgenerate

  logic [WW-1:0]    if_word;
  logic [WW-1:0]    d_word;
  logic             if_oor;
  logic             d_oor;
  logic             force_if;
  logic             if_win;
  logic             d_win;
  logic             any_win;
  logic             sel_oor;
  logic [WW-1:0]    sel_word;
  logic [CNT_W-1:0] starve_cnt;
  tag_t             push;
  tag_t             tail;
  logic             unused_addr_lsbs;

  assign if_word = if_addr[ADDR_W-1:2];
  assign d_word  = d_addr[ADDR_W-1:2];
  assign if_oor  = {2'b00, if_word} >= DEPTH_LIM;
  assign d_oor   = {2'b00, d_word} >= DEPTH_LIM;

  // Byte offset within a word plays no part in a word-wide BRAM access.
  assign unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

  // Grants are gated by rst_n so every output reads 0 while reset is held.
  always_comb begin
    force_if = (STARVE_MAX != 0) && (starve_cnt == STARVE_LIM);
    d_win    = rst_n && d_req && !(if_req && force_if);
    if_win   = rst_n && if_req && !d_win;
    any_win  = d_win || if_win;
    sel_word = d_win ? d_word : if_word;
    sel_oor  = d_win ? d_oor : if_oor;
  end

  assign if_gnt = if_win;
  assign d_gnt  = d_win;

  always_comb begin
    bram_en    = any_win && !sel_oor;
    bram_we    = d_win && d_we && !d_oor;
    bram_addr  = any_win ? sel_word[AW-1:0] : '0;
    bram_wdata = (d_win && d_we) ? d_wdata : '0;
  end

  always_comb begin
    push = TAG_IDLE;
    if (if_win) begin
      push = '{valid: 1'b1, src: SRC_IF, oor: if_oor};
    end else if (d_win && !d_we) begin
      push = '{valid: 1'b1, src: SRC_D, oor: d_oor};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (if_req && d_win) begin
      if (starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  arb_tag_pipe #(
    .LAT(LAT)
  ) u_tag_pipe (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .tail (tail),
    .busy (busy)
  );

  always_comb begin
    if_rvalid = tail.valid && (tail.src == SRC_IF);
    d_rvalid  = tail.valid && (tail.src == SRC_D);
    if_rdata  = '0;
    d_rdata   = '0;
    if (if_rvalid) begin
      if_rdata = tail.oor ? DATA_W'(RV_NOP) : bram_rdata;
    end
    if (d_rvalid) begin
      d_rdata = tail.oor ? '0 : bram_rdata;
    end
  end

endmodule

// File: doc/rv_bram_port_arbiter.md
Name: rv_bram_port_arbiter

Overview:
- Shares one single-port, fixed-latency BRAM between the pipelined core's instruction-fetch port and data-memory port.
- Grants at most one access per cycle and tracks in-flight reads through a LAT-deep tag pipeline, so each read response is steered to the port that issued it.
- Starvation-limited priority: data wins by default, and fetch is forced through after a bounded number of lost conflicts.
- Sits between rv_pl's F_pc/F_instr and M_ALUResult/M_WriteData/M_ReadDataW paths and the BRAM primitive.

Parameters:
ADDR_W, 32, byte-address width of both requester ports
DATA_W, 32, data width
LAT, 2, BRAM read latency in cycles (legal 1..4)
DEPTH, 256, BRAM depth in words
STARVE_MAX, 4, consecutive fetch losses before fetch is forced to win; 0 = data always wins

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch read request
if_addr  in  ADDR_W  fetch byte address
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  fetch read data valid
if_rdata  out  DATA_W  fetch read data
d_req  in  1  data request
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  data byte address
d_wdata  in  DATA_W  write data
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  data read data valid
d_rdata  out  DATA_W  data read data
bram_en  out  1  BRAM enable
bram_we  out  1  BRAM write enable
bram_addr  out  $clog2(DEPTH)  BRAM word address
bram_wdata  out  DATA_W  BRAM write data
bram_rdata  in  DATA_W  BRAM read data, valid LAT cycles after bram_en
busy  out  1  any read in flight

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: while rst_n=0, every output is 0. The tag pipeline and the starve counter are cleared.
- Reset mid-operation: all in-flight reads are discarded. No rvalid pulse occurs after rst_n rises, even though bram_rdata keeps changing.
- Grant: combinational in the same cycle as the request.
  - Only one of d_req/if_req is high: that port is granted.
  - Both are high: d wins, unless starve_cnt == STARVE_MAX with STARVE_MAX != 0, in which case if wins.
- Requester rule: a requester whose gnt is low holds req and its address/data stable until granted.
- BRAM drive: the winner's word address (addr[ADDR_W-1:2]) goes combinationally to bram_addr. bram_en=1 and bram_we=d_we (data winner only). Low address bits [1:0] are ignored.
- Out-of-range access (word index >= DEPTH):
  - Still granted, with bram_en=0.
  - Writes are dropped.
  - Reads return a synthetic response after LAT cycles: 32'h00000013 (NOP) on the fetch port, 0 on the data port.
- Tag pipeline: LAT stages of {valid, src, oor}, shifted every cycle.
  - A granted read pushes valid=1.
  - Writes and idle cycles push valid=0.
- Response: when the last stage has valid=1, that port's rvalid is asserted and its rdata = bram_rdata, or the synthetic value if oor=1. Exactly LAT cycles after the grant cycle.
  - The rdata of a non-owning port is don't-care and is driven as 0.
- Throughput and ordering: one access per cycle. Back-to-back reads from either port are fully pipelined. Responses return in issue order.
- Read-after-write to the same address in consecutive cycles returns the new data; this is a BRAM property that the arbiter relies on.
- Starve counter, width $clog2(STARVE_MAX+1), saturating:
  - Increments when if_req=1 and d wins.
  - Clears when if wins or when if_req=0.
- busy = OR of the valid bits in the tag pipeline.

Decomposition:
- Package rv_mem_arb_pkg holds:
  - src encoding SRC_IF=1'b0, SRC_D=1'b1
  - constant RV_NOP=32'h00000013
  - the tag record type {valid, src, oor}
- Sub-module arb_tag_pipe: a LAT-deep tag shift register with asynchronous clear.
- Arbitration, the starve counter and the response steering stay in the top module.

Test Plan:
- Fetch-only stream, LAT=2, if_addr 0x00, 0x04, 0x08 on consecutive cycles, BRAM words 0x93, 0x113, 0x00108093 -> if_gnt=1 for each; if_rvalid on cycles t+2..t+4 with data in that order.
- Conflict: d_req read 0x10 and if_req 0x20 in the same cycle -> d_gnt=1, if_gnt=0. Next cycle if_gnt=1. d_rvalid at t+2, if_rvalid at t+3.
- Starvation, STARVE_MAX=4: d_req and if_req held high continuously -> d wins 4 cycles, if wins on the 5th, then the pattern repeats. No cycle has both gnt high.
- Write then read: d write 0x0 data 3, then d read 0x0 -> bram_we pulses once; d_rvalid 2 cycles after the read grant with d_rdata=3; no rvalid for the write.
- Out of range: if read 0x400 (word 256) -> bram_en=0, if_rvalid after 2 cycles with 0x00000013. d read 0x400 -> d_rdata=0.
- Reset mid-flight: issue 2 reads, drop rst_n for one cycle after the grant -> all outputs 0 during reset; no rvalid after release; busy=0.
